// File: rtl/bram_loader.sv
// Byte-stream to 16-bit RAM port-A loader: packs byte pairs high byte first and writes WORD_COUNT words from START_ADDR.
// Latency: one write cycle after the low byte is accepted (plus RD/CMP readback when BRAM_LOADER_VERIFY_EN is defined).
// Backpressure: in_ready is high only while waiting for a byte; a stalled stream parks the loader in HI/LO until reset.
module bram_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int START_ADDR = 0,
    parameter int WORD_COUNT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [15:0]           data_a,
    output logic                  we_a,
    input  logic [15:0]           q_a,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(START_ADDR);
    localparam logic [CW-1:0]         LAST_IDX   = CW'(WORD_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WRITE,
        S_DONE
`ifdef BRAM_LOADER_VERIFY_EN
        , S_RD,
        S_CMP
`endif
    } state_t;

    state_t          state, state_n;
    logic [7:0]      hi_byte;
    logic [CW-1:0]   count;
    logic            last;

    assign last = (count == LAST_IDX);

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        we_a     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_HI;
            end
            S_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_n = S_LO;
            end
            S_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_n = S_WRITE;
            end
            S_WRITE: begin
                we_a = 1'b1;
                busy = 1'b1;
`ifdef BRAM_LOADER_VERIFY_EN
                state_n = S_RD;
`else
                state_n = last ? S_DONE : S_HI;
`endif
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_n = S_HI;
            end
`ifdef BRAM_LOADER_VERIFY_EN
            S_RD: begin
                busy    = 1'b1;
                state_n = S_CMP;
            end
            S_CMP: begin
                busy    = 1'b1;
                state_n = last ? S_DONE : S_HI;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            addr_a  <= FIRST_ADDR;
            data_a  <= 16'h0000;
            hi_byte <= 8'h00;
            count   <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr_a <= FIRST_ADDR;
                        count  <= '0;
                    end
                end
                S_HI: begin
                    if (in_valid) hi_byte <= in_data;
                end
                S_LO: begin
                    if (in_valid) data_a <= {hi_byte, in_data};
                end
`ifdef BRAM_LOADER_VERIFY_EN
                S_CMP: begin
                    if (!last) begin
                        addr_a <= addr_a + 1'b1;
                        count  <= count + 1'b1;
                    end
                end
`else
                S_WRITE: begin
                    // address wraps naturally at 2**ADDR_WIDTH
                    if (!last) begin
                        addr_a <= addr_a + 1'b1;
                        count  <= count + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef BRAM_LOADER_VERIFY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if ((state == S_IDLE || state == S_DONE) && start) begin
            err <= 1'b0;
        end else if (state == S_CMP && q_a != data_a) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_q;
    assign unused_q = ^q_a;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader: two instances (START_ADDR 0 and 1022, WORD_COUNT 4) each backed by a behavioural RAM.
module tb_bram_loader;

`ifdef BRAM_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [9:0]  addr;
        logic [15:0] word;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  start;
    logic [1:0]  in_valid;
    logic [7:0]  in_data [2];
    logic [1:0]  in_ready;
    logic [1:0]  we_a;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [9:0]  addr_a [2];
    logic [15:0] data_a [2];
    logic [15:0] q_a [2];

    logic [1:0]  clr;
    logic [1:0]  corrupt;
    logic [15:0] mem [2][1024];
    logic [25:0] wlog [2][64];
    int          wcnt [2];
    int          wdbl [2];
    int          acc [2];
    bit  [1:0]   we_prev;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    vec_t        vt [2][4];

    always #5 clk = ~clk;

    bram_loader #(.ADDR_WIDTH(10), .START_ADDR(0), .WORD_COUNT(4)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .addr_a(addr_a[0]), .data_a(data_a[0]), .we_a(we_a[0]),
        .q_a(q_a[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    bram_loader #(.ADDR_WIDTH(10), .START_ADDR(1022), .WORD_COUNT(4)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .addr_a(addr_a[1]), .data_a(data_a[1]), .we_a(we_a[1]),
        .q_a(q_a[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    // RAM model with registered read, plus write/accept monitors
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (clr[d]) begin
                for (int i = 0; i < 1024; i++) mem[d][i] <= 16'hDEAD;
            end else if (we_a[d]) begin
                mem[d][addr_a[d]] <= data_a[d];
            end
            q_a[d] <= (corrupt[d] && addr_a[d] == 10'd2) ? 16'h0000 : mem[d][addr_a[d]];
            if (we_a[d]) begin
                wlog[d][wcnt[d] % 64] <= {addr_a[d], data_a[d]};
                wcnt[d] <= wcnt[d] + 1;
            end
            if (we_a[d] && we_prev[d]) wdbl[d] <= wdbl[d] + 1;
            we_prev[d] <= we_a[d];
            if (in_valid[d] && in_ready[d]) acc[d] <= acc[d] + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
    endtask

    task automatic clear_mem(input int d);
        clr[d] = 1'b1;
        tick();
        clr[d] = 1'b0;
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, input int mode, input int gap);
        bit got;
        got = 1'b0;
        in_valid[d] = 1'b0;
        repeat (gap) tick();
        if (mode == 1) repeat ($urandom_range(0, 3)) tick();
        in_valid[d] = 1'b1;
        in_data[d]  = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("byte_accept_timeout", 32'd0, 32'd1);
        tick();
        in_valid[d] = 1'b0;
    endtask

    task automatic send_words(input int d, input int mode, input int from);
        for (int i = from; i < 4; i++) begin
            send_byte(d, vt[d][i].hi, mode, 0);
            send_byte(d, vt[d][i].lo, mode, (mode == 1 && i == 1) ? 10 : 0);
        end
    endtask

    // junk is offered while waiting: it must not be taken in WRITE/RD/CMP/DONE
    task automatic wait_done(input int d);
        in_valid[d] = 1'b1;
        in_data[d]  = 8'hEE;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done[d]) break;
        end
        repeat (3) tick();
        in_valid[d] = 1'b0;
    endtask

    task automatic check_load(input int d, input int wbase, input int abase, input logic exp_err);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wlog%0d_%0d", d, i), 32'(wlog[d][(wbase + i) % 64]),
                32'({vt[d][i].addr, vt[d][i].word}));
            chk($sformatf("mem%0d_%0d", d, i), 32'(mem[d][vt[d][i].addr]), 32'(vt[d][i].word));
        end
        chk("write_count", 32'(wcnt[d] - wbase), 32'd4);
        chk("bytes_taken", 32'(acc[d] - abase), 32'd8);
        chk("we_single_cycle", 32'(wdbl[d]), 32'd0);
        chk("done_end", 32'(done[d]), 32'd1);
        chk("busy_end", 32'(busy[d]), 32'd0);
        chk("err_end", 32'(err[d]), 32'(exp_err));
    endtask

    initial begin
        int wb, ab;
        vt[0][0] = '{8'h12, 8'h34, 10'd0,    16'h1234};
        vt[0][1] = '{8'h56, 8'h78, 10'd1,    16'h5678};
        vt[0][2] = '{8'h9A, 8'hBC, 10'd2,    16'h9ABC};
        vt[0][3] = '{8'hDE, 8'hF0, 10'd3,    16'hDEF0};
        vt[1][0] = '{8'hA1, 8'hB2, 10'd1022, 16'hA1B2};
        vt[1][1] = '{8'hC3, 8'hD4, 10'd1023, 16'hC3D4};
        vt[1][2] = '{8'hE5, 8'hF6, 10'd0,    16'hE5F6};
        vt[1][3] = '{8'h07, 8'h18, 10'd1,    16'h0718};

        rst = 1'b0; start = '0; in_valid = '0; in_data[0] = 8'h00; in_data[1] = 8'h00;
        clr = '0; corrupt = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        chk("rst_in_ready0", 32'(in_ready[0]), 32'd0);
        chk("rst_we0", 32'(we_a[0]), 32'd0);
        chk("rst_addr0", 32'(addr_a[0]), 32'd0);
        chk("rst_addr1", 32'(addr_a[1]), 32'd1022);
        chk("rst_data0", 32'(data_a[0]), 32'd0);
        chk("rst_flags0", 32'({busy[0], done[0], err[0]}), 32'd0);

        // reset taken mid-HI, then start is needed to resume
        pulse_start(0);
        chk("hi_ready", 32'(in_ready[0]), 32'd1);
        chk("hi_busy", 32'(busy[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_ready", 32'(in_ready[0]), 32'd0);
        chk("async_rst_busy", 32'(busy[0]), 32'd0);
        tick();
        rst = 1'b1;
        in_valid[0] = 1'b1;
        repeat (3) tick();
        chk("post_rst_ready", 32'(in_ready[0]), 32'd0);
        chk("post_rst_busy", 32'(busy[0]), 32'd0);
        chk("post_rst_done", 32'(done[0]), 32'd0);
        chk("post_rst_addr", 32'(addr_a[0]), 32'd0);
        in_valid[0] = 1'b0;

        // back-to-back bytes
        clear_mem(0);
        wb = wcnt[0]; ab = acc[0];
        pulse_start(0);
        send_words(0, 0, 0);
        wait_done(0);
        check_load(0, wb, ab, 1'b0);

        // irregular valid with a 10-cycle gap inside word 1
        clear_mem(0);
        wb = wcnt[0]; ab = acc[0];
        pulse_start(0);
        send_words(0, 1, 0);
        wait_done(0);
        check_load(0, wb, ab, 1'b0);

        // address wrap 1022, 1023, 0, 1
        clear_mem(1);
        wb = wcnt[1]; ab = acc[1];
        pulse_start(1);
        send_words(1, 0, 0);
        wait_done(1);
        check_load(1, wb, ab, 1'b0);

        // start pulses inside a load are ignored
        clear_mem(0);
        wb = wcnt[0]; ab = acc[0];
        pulse_start(0);
        send_byte(0, vt[0][0].hi, 0, 0);
        pulse_start(0);
        send_byte(0, vt[0][0].lo, 0, 0);
        pulse_start(0);
        chk("busy_after_ignored_start", 32'(busy[0]), 32'd1);
        send_words(0, 0, 1);
        wait_done(0);
        check_load(0, wb, ab, 1'b0);

        // restart from DONE
        clear_mem(0);
        wb = wcnt[0]; ab = acc[0];
        pulse_start(0);
        chk("restart_done", 32'(done[0]), 32'd0);
        chk("restart_busy", 32'(busy[0]), 32'd1);
        chk("restart_addr", 32'(addr_a[0]), 32'd0);
        send_words(0, 0, 0);
        wait_done(0);
        check_load(0, wb, ab, 1'b0);

        // corrupted readback of word 2: err only exists with the verify build
        clear_mem(0);
        corrupt[0] = 1'b1;
        wb = wcnt[0]; ab = acc[0];
        pulse_start(0);
        send_words(0, 0, 0);
        wait_done(0);
        check_load(0, wb, ab, VERIFY);
        repeat (4) tick();
        chk("err_sticky_in_done", 32'(err[0]), 32'(VERIFY));
        corrupt[0] = 1'b0;
        pulse_start(0);
        chk("err_cleared_on_start", 32'(err[0]), 32'd0);
        wb = wcnt[0]; ab = acc[0];
        send_words(0, 0, 0);
        wait_done(0);
        check_load(0, wb, ab, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
